// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state encoding and default constants for the SAR controller
package sar_pkg;

   localparam int NBITS_DEF        = 10;
   localparam int TRIM_BITS_DEF    = 5;
   localparam int CAL_ITT_DEF      = 7;
   localparam int NCH_DEF          = 4;
   localparam int MAX_AVG_LOG2_DEF = 3;

   typedef enum logic [2:0] {
      INIT,
      WAIT,
      SAMPLE,
      CONV,
      ACC,
      DONE,
      CAL
   } sar_state_t;

endpackage

// File: rtl/sar_trim_cal.sv
// rtl/sar_trim_cal.sv - comparator offset-trim calibration: majority vote per trim bit
module sar_trim_cal
   import sar_pkg::*;
#(
   parameter int TRIM_BITS = TRIM_BITS_DEF,
   parameter int CAL_ITT   = CAL_ITT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init,
   input  logic                 start,
   input  logic                 active,
   input  logic                 comp,
   output logic [TRIM_BITS-1:0] trim_val,
   output logic [TRIM_BITS-1:0] trim_mask,
   output logic                 done
);

   localparam int CW = $clog2(CAL_ITT + 1);
   localparam logic [TRIM_BITS-1:0] TRIM_MSB = {1'b1, {(TRIM_BITS-1){1'b0}}};

   logic [CW-1:0] itt_cnt;
   logic [CW-1:0] zero_cnt;
   logic [CW-1:0] zero_tot;
   logic          itt_last;

   // zero_tot includes the comparison being made this cycle
   assign zero_tot = zero_cnt + CW'(!comp);
   assign itt_last = (itt_cnt == CW'(CAL_ITT - 1));
   assign done     = active && itt_last && trim_mask[0];

   // Walk the trim bits MSB-first, keeping a bit when comp=0 wins the vote
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trim_val  <= '0;
         trim_mask <= '0;
         itt_cnt   <= '0;
         zero_cnt  <= '0;
      end else if (init) begin
         trim_val <= TRIM_MSB;
      end else if (start) begin
         trim_val  <= '0;
         trim_mask <= TRIM_MSB;
         itt_cnt   <= '0;
         zero_cnt  <= '0;
      end else if (active) begin
         if (itt_last) begin
            if (zero_tot > CW'(CAL_ITT / 2))
               trim_val <= trim_val | trim_mask;
            trim_mask <= trim_mask >> 1;
            itt_cnt   <= '0;
            zero_cnt  <= '0;
         end else begin
            itt_cnt  <= itt_cnt + CW'(1);
            zero_cnt <= zero_tot;
         end
      end
   end

endmodule

// File: rtl/sar_ctrl_gen.sv
// rtl/sar_ctrl_gen.sv - SAR ADC sequencer with averaging, channel scan and trim calibration
module sar_ctrl_gen
   import sar_pkg::*;
#(
   parameter int NBITS        = NBITS_DEF,
   parameter int TRIM_BITS    = TRIM_BITS_DEF,
   parameter int CAL_ITT      = CAL_ITT_DEF,
   parameter int NCH          = NCH_DEF,
   parameter int MAX_AVG_LOG2 = MAX_AVG_LOG2_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            cal,
   input  logic                            scan,
   input  logic [$clog2(NCH)-1:0]          ch_start,
   input  logic [$clog2(MAX_AVG_LOG2+1)-1:0] avg_log2,
   input  logic                            comp,
   output logic                            valid,
   output logic [NBITS-1:0]                result,
   output logic [$clog2(NCH)-1:0]          result_ch,
   output logic                            busy,
   output logic [$clog2(NCH)-1:0]          ch_sel,
   output logic                            sample,
   output logic [NBITS-1:0]                ctlp,
   output logic [NBITS-1:0]                ctln,
   output logic [TRIM_BITS-1:0]            trim,
   output logic [TRIM_BITS-1:0]            trimb,
   output logic                            clkc
);

   localparam int CHW  = $clog2(NCH);
   localparam int AVW  = $clog2(MAX_AVG_LOG2 + 1);
   localparam int AVCW = MAX_AVG_LOG2 + 1;
   localparam int ACCW = NBITS + MAX_AVG_LOG2;
   localparam logic [NBITS-1:0] MSB = {1'b1, {(NBITS-1){1'b0}}};

   sar_state_t       state, state_nxt;
   logic             cal_lat, scan_lat, clk_en;
   logic [AVW-1:0]   avg_lat, avg_in;
   logic [AVCW-1:0]  avg_cnt;
   logic [NBITS-1:0] sar_reg, mask;
   logic [ACCW-1:0]  acc, acc_sum;
   logic             avg_last, ch_last;
   logic [TRIM_BITS-1:0] trim_val, trim_mask;
   logic             cal_done;

   assign avg_in   = (avg_log2 > AVW'(MAX_AVG_LOG2)) ? AVW'(MAX_AVG_LOG2) : avg_log2;
   assign acc_sum  = acc + ACCW'(sar_reg);
   assign avg_last = (avg_cnt == ((AVCW'(1) << avg_lat) - AVCW'(1)));
   assign ch_last  = (ch_sel == CHW'(NCH - 1));

   assign ctlp  = sar_reg | mask;
   assign ctln  = ~ctlp;
   assign trim  = trim_val | trim_mask;
   assign trimb = ~trim;
   assign clkc  = ~clk & clk_en;

   sar_trim_cal #(
      .TRIM_BITS (TRIM_BITS),
      .CAL_ITT   (CAL_ITT)
   ) u_trim_cal (
      .clk       (clk),
      .rst       (rst),
      .init      (state == INIT),
      .start     ((state == SAMPLE) && cal_lat && en),
      .active    (state == CAL),
      .comp      (comp),
      .trim_val  (trim_val),
      .trim_mask (trim_mask),
      .done      (cal_done)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= INIT;
      else     state <= state_nxt;
   end

   // Next-state decode and per-state strobes
   always_comb begin
      state_nxt = state;
      valid     = 1'b0;
      sample    = 1'b0;
      busy      = 1'b1;
      case (state)
         INIT: begin
            busy      = 1'b0;
            state_nxt = WAIT;
         end
         WAIT: begin
            busy = 1'b0;
            if (en) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            sample = 1'b1;
            if (!en)         state_nxt = WAIT;
            else if (cal_lat) state_nxt = CAL;
            else             state_nxt = CONV;
         end
         CONV: begin
            if (!en)          state_nxt = WAIT;
            else if (mask[0]) state_nxt = ACC;
         end
         ACC: begin
            if (!en)           state_nxt = WAIT;
            else if (avg_last) state_nxt = DONE;
            else               state_nxt = SAMPLE;
         end
         DONE: begin
            valid = 1'b1;
            if (scan_lat && en && !ch_last && !cal_lat) state_nxt = SAMPLE;
            else                                         state_nxt = WAIT;
         end
         CAL: begin
            sample = 1'b1;
            if (cal_done) state_nxt = DONE;
         end
         default: state_nxt = INIT;
      endcase
   end

   // Conversion datapath: SAR register, averaging accumulator, channel and comparator clock gate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cal_lat   <= 1'b0;
         scan_lat  <= 1'b0;
         avg_lat   <= '0;
         avg_cnt   <= '0;
         ch_sel    <= '0;
         sar_reg   <= '0;
         mask      <= '0;
         acc       <= '0;
         result    <= '0;
         result_ch <= '0;
         clk_en    <= 1'b0;
      end else begin
         case (state)
            WAIT: if (en) begin
               cal_lat  <= cal;
               scan_lat <= scan;
               avg_lat  <= avg_in;
               ch_sel   <= ch_start;
               acc      <= '0;
               avg_cnt  <= '0;
               sar_reg  <= '0;
               mask     <= MSB;
               clk_en   <= 1'b1;
            end
            SAMPLE: if (!en) clk_en <= 1'b0;
            CONV: begin
               if (!en) begin
                  clk_en <= 1'b0;
               end else begin
                  if (comp) sar_reg <= sar_reg | mask;
                  mask <= mask >> 1;
               end
            end
            ACC: begin
               if (!en) begin
                  clk_en <= 1'b0;
               end else begin
                  acc <= acc_sum;
                  if (avg_last) begin
                     result    <= NBITS'(acc_sum >> avg_lat);
                     result_ch <= ch_sel;
                     clk_en    <= 1'b0;
                  end else begin
                     avg_cnt <= avg_cnt + AVCW'(1);
                     sar_reg <= '0;
                     mask    <= MSB;
                  end
               end
            end
            DONE: if (state_nxt == SAMPLE) begin
               ch_sel  <= ch_sel + CHW'(1);
               acc     <= '0;
               avg_cnt <= '0;
               sar_reg <= '0;
               mask    <= MSB;
               clk_en  <= 1'b1;
            end
            CAL: if (cal_done) clk_en <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_ctrl_gen.sv
// tb/tb_sar_ctrl_gen.sv - directed self-checking bench for sar_ctrl_gen
module tb_sar_ctrl_gen;

   logic       clk = 1'b0;
   logic       rst, en, cal, scan, comp;
   logic [1:0] ch_start, avg_log2;
   logic       valid, busy, sample, clkc;
   logic [9:0] result, ctlp, ctln;
   logic [1:0] result_ch, ch_sel;
   logic [4:0] trim, trimb;

   int nvec = 0;
   int nerr = 0;
   logic [9:0] exp_result;

   sar_ctrl_gen dut (
      .clk(clk), .rst(rst), .en(en), .cal(cal), .scan(scan),
      .ch_start(ch_start), .avg_log2(avg_log2), .comp(comp),
      .valid(valid), .result(result), .result_ch(result_ch), .busy(busy),
      .ch_sel(ch_sel), .sample(sample), .ctlp(ctlp), .ctln(ctln),
      .trim(trim), .trimb(trimb), .clkc(clkc)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // From SAMPLE: one edge into CONV, then feed the code MSB-first; ends in ACC
   task automatic run_conv(input logic [9:0] code);
      tick;
      for (int k = 0; k < 10; k++) begin
         comp = code[9-k];
         tick;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 0; cal = 0; scan = 0; comp = 0; ch_start = 0; avg_log2 = 0;
      tick; tick;
      #5;
      nvec++; if (valid !== 1'b0)      begin nerr++; $display("FAIL rst_valid got %b want 0", valid); end
      nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
      nvec++; if (sample !== 1'b0)     begin nerr++; $display("FAIL rst_sample got %b want 0", sample); end
      nvec++; if (clkc !== 1'b0)       begin nerr++; $display("FAIL rst_clkc got %b want 0", clkc); end
      nvec++; if (result !== 10'h0)    begin nerr++; $display("FAIL rst_result got %h want 000", result); end
      nvec++; if (result_ch !== 2'd0)  begin nerr++; $display("FAIL rst_result_ch got %0d want 0", result_ch); end
      nvec++; if (ch_sel !== 2'd0)     begin nerr++; $display("FAIL rst_ch_sel got %0d want 0", ch_sel); end
      nvec++; if (ctln !== 10'h3FF)    begin nerr++; $display("FAIL rst_ctln got %h want 3ff", ctln); end
      nvec++; if (trimb !== 5'b11111)  begin nerr++; $display("FAIL rst_trimb got %b want 11111", trimb); end
      tick;
      rst = 1'b0;
      tick;
      nvec++; if (trim !== 5'b10000)   begin nerr++; $display("FAIL init_trim got %b want 10000", trim); end
      nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL wait_busy got %b want 0", busy); end
   endtask

   task automatic test_single;
      en = 1; avg_log2 = 0; ch_start = 0;
      tick;
      nvec++; if (sample !== 1'b1) begin nerr++; $display("FAIL single_sample got %b want 1", sample); end
      #5;
      nvec++; if (clkc !== 1'b1)   begin nerr++; $display("FAIL single_clkc got %b want 1", clkc); end
      run_conv(10'h2A5);
      nvec++; if (valid !== 1'b0)  begin nerr++; $display("FAIL single_early_valid got %b want 0", valid); end
      tick;
      exp_result = 10'h2A5;
      nvec++; if (valid !== 1'b1)       begin nerr++; $display("FAIL single_valid got %b want 1", valid); end
      nvec++; if (result !== 10'h2A5)   begin nerr++; $display("FAIL single_result got %h want 2a5", result); end
      nvec++; if (ctlp !== 10'h2A5)     begin nerr++; $display("FAIL single_ctlp got %h want 2a5", ctlp); end
      nvec++; if (result_ch !== 2'd0)   begin nerr++; $display("FAIL single_ch got %0d want 0", result_ch); end
      en = 0;
      tick;
      nvec++; if (valid !== 1'b0)  begin nerr++; $display("FAIL single_one_shot got %b want 0", valid); end
      nvec++; if (busy !== 1'b0)   begin nerr++; $display("FAIL single_idle got %b want 0", busy); end
   endtask

   task automatic test_avg;
      logic [9:0] codes [4];
      codes[0] = 10'd100; codes[1] = 10'd101; codes[2] = 10'd102; codes[3] = 10'd103;
      en = 1; avg_log2 = 2;
      tick;
      for (int i = 0; i < 4; i++) begin
         run_conv(codes[i]);
         tick;
         if (i < 3) begin
            nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL avg_valid_%0d got %b want 0", i, valid); end
         end
      end
      exp_result = 10'd101;
      nvec++; if (valid !== 1'b1)      begin nerr++; $display("FAIL avg_valid got %b want 1", valid); end
      nvec++; if (result !== 10'd101)  begin nerr++; $display("FAIL avg_result got %0d want 101", result); end
      en = 0;
      tick;
   endtask

   task automatic test_trunc;
      en = 1; avg_log2 = 1;
      tick;
      run_conv(10'h3FF);
      tick;
      run_conv(10'h3FE);
      tick;
      exp_result = 10'h3FE;
      nvec++; if (valid !== 1'b1)     begin nerr++; $display("FAIL trunc_valid got %b want 1", valid); end
      nvec++; if (result !== 10'h3FE) begin nerr++; $display("FAIL trunc_result got %h want 3fe", result); end
      en = 0;
      tick;
   endtask

   task automatic test_scan;
      logic [9:0] codes [4];
      codes[1] = 10'h155; codes[2] = 10'h0AA; codes[3] = 10'h3C3; codes[0] = 10'h0;
      en = 1; scan = 1; ch_start = 1; avg_log2 = 0;
      tick;
      for (int ch = 1; ch < 4; ch++) begin
         run_conv(codes[ch]);
         tick;
         nvec++; if (valid !== 1'b1)          begin nerr++; $display("FAIL scan_valid_%0d got %b want 1", ch, valid); end
         nvec++; if (result_ch !== 2'(ch))    begin nerr++; $display("FAIL scan_ch_%0d got %0d want %0d", ch, result_ch, ch); end
         nvec++; if (result !== codes[ch])    begin nerr++; $display("FAIL scan_result_%0d got %h want %h", ch, result, codes[ch]); end
         if (ch == 3) en = 0;
         tick;
         if (ch < 3) begin
            nvec++; if (ch_sel !== 2'(ch + 1)) begin nerr++; $display("FAIL scan_next_%0d got %0d want %0d", ch, ch_sel, ch + 1); end
         end
      end
      exp_result = 10'h3C3;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL scan_end_busy got %b want 0", busy); end
   endtask

   task automatic test_scan_last;
      en = 1; scan = 1; ch_start = 3;
      tick;
      run_conv(10'h071);
      tick;
      exp_result = 10'h071;
      nvec++; if (valid !== 1'b1)     begin nerr++; $display("FAIL last_valid got %b want 1", valid); end
      nvec++; if (result_ch !== 2'd3) begin nerr++; $display("FAIL last_ch got %0d want 3", result_ch); end
      tick;
      nvec++; if (busy !== 1'b0)      begin nerr++; $display("FAIL last_no_wrap got %b want 0", busy); end
      en = 0; scan = 0; ch_start = 0;
      tick;
   endtask

   task automatic test_cal(input bit zeros_win, input logic [4:0] want);
      en = 1; cal = 1;
      tick;
      tick;
      en = 0;
      nvec++; if (sample !== 1'b1)   begin nerr++; $display("FAIL cal_sample got %b want 1", sample); end
      nvec++; if (trim !== 5'b10000) begin nerr++; $display("FAIL cal_first_trial got %b want 10000", trim); end
      for (int b = 0; b < 5; b++) begin
         for (int j = 0; j < 7; j++) begin
            comp = (j < 4) ? ~zeros_win : zeros_win;
            if (b != 4 || j != 6) begin
               nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL cal_early_valid got %b want 0", valid); end
            end
            tick;
         end
      end
      nvec++; if (valid !== 1'b1)      begin nerr++; $display("FAIL cal_valid got %b want 1", valid); end
      nvec++; if (trim !== want)       begin nerr++; $display("FAIL cal_trim got %b want %b", trim, want); end
      nvec++; if (trimb !== ~want)     begin nerr++; $display("FAIL cal_trimb got %b want %b", trimb, ~want); end
      nvec++; if (result !== exp_result) begin nerr++; $display("FAIL cal_result got %h want %h", result, exp_result); end
      cal = 0;
      tick;
      nvec++; if (valid !== 1'b0)      begin nerr++; $display("FAIL cal_one_shot got %b want 0", valid); end
      nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL cal_idle got %b want 0", busy); end
   endtask

   task automatic test_abort;
      en = 1; avg_log2 = 0;
      tick;
      tick;
      for (int k = 0; k < 4; k++) begin
         comp = 1;
         tick;
      end
      #5;
      nvec++; if (clkc !== 1'b1)  begin nerr++; $display("FAIL abort_clkc_on got %b want 1", clkc); end
      en = 0;
      tick;
      nvec++; if (busy !== 1'b0)  begin nerr++; $display("FAIL abort_busy got %b want 0", busy); end
      nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL abort_valid got %b want 0", valid); end
      #5;
      nvec++; if (clkc !== 1'b0)  begin nerr++; $display("FAIL abort_clkc_off got %b want 0", clkc); end
      for (int i = 0; i < 3; i++) begin
         tick;
         nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL abort_late_valid got %b want 0", valid); end
      end
      nvec++; if (result !== exp_result) begin nerr++; $display("FAIL abort_result got %h want %h", result, exp_result); end
   endtask

   task automatic test_rst_cal;
      en = 1; cal = 1; comp = 0;
      tick;
      tick;
      en = 0;
      for (int i = 0; i < 10; i++) tick;
      #2;
      rst = 1;
      #1;
      nvec++; if (trim !== 5'b00000) begin nerr++; $display("FAIL rstcal_trim got %b want 00000", trim); end
      nvec++; if (sample !== 1'b0)   begin nerr++; $display("FAIL rstcal_sample got %b want 0", sample); end
      nvec++; if (result !== 10'h0)  begin nerr++; $display("FAIL rstcal_result got %h want 000", result); end
      cal = 0;
      tick;
      rst = 0;
      tick;
      tick;
      nvec++; if (trim !== 5'b10000) begin nerr++; $display("FAIL rstcal_reinit got %b want 10000", trim); end
      nvec++; if (busy !== 1'b0)     begin nerr++; $display("FAIL rstcal_busy got %b want 0", busy); end
   endtask

   initial begin
      exp_result = 10'h0;
      test_reset;
      test_single;
      test_avg;
      test_trunc;
      test_scan;
      test_scan_last;
      test_cal(1'b1, 5'b11111);
      test_cal(1'b0, 5'b00000);
      test_abort;
      test_rst_cal;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
